// File: rtl/dm_arbiter.sv
// Shares one synchronous data-memory port between master 0 (CPU) and master 1 (DMA/loader), round-robin with bounded tenure.
// Latency: grant is combinational (0 cycles); read data and rvalid return 1 cycle after the accepted read.
// Backpressure: a requester without gnt holds req; under contention an owner keeps at most BURST_MAX consecutive beats.
module dm_arbiter #(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int BURST_MAX = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              m0_req,
    input  logic              m0_write,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    output logic              m0_gnt,
    output logic              m0_rvalid,
    output logic [DATA_W-1:0] m0_rdata,
    input  logic              m1_req,
    input  logic              m1_write,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    output logic              m1_gnt,
    output logic              m1_rvalid,
    output logic [DATA_W-1:0] m1_rdata,
    output logic              DM_enable,
    output logic              DM_write,
    output logic [ADDR_W-1:0] DM_address,
    output logic [DATA_W-1:0] DM_in,
    input  logic [DATA_W-1:0] DM_out
);

    localparam int CNT_W = $clog2(BURST_MAX + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(BURST_MAX);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             last, last_nxt;
    logic             rpend, rpend_nxt;
    logic             rsel, rsel_nxt;

    logic             win_vld;
    logic             win_sel;
    logic             win_write;
    logic             cnt_full;
    state_t           win_state;

    // Winner selection: round-robin from IDLE, tenure-limited while owning.
    always_comb begin
        win_vld  = 1'b0;
        win_sel  = 1'b0;
        cnt_full = (cnt == CNT_MAX);
        case (state)
            IDLE: begin
                if (m0_req && m1_req) begin
                    win_vld = 1'b1;
                    win_sel = ~last;
                end else if (m0_req) begin
                    win_vld = 1'b1;
                    win_sel = 1'b0;
                end else if (m1_req) begin
                    win_vld = 1'b1;
                    win_sel = 1'b1;
                end
            end
            OWN0: begin
                if (m0_req && !(cnt_full && m1_req)) begin
                    win_vld = 1'b1;
                    win_sel = 1'b0;
                end else if (m1_req) begin
                    win_vld = 1'b1;
                    win_sel = 1'b1;
                end
            end
            OWN1: begin
                if (m1_req && !(cnt_full && m0_req)) begin
                    win_vld = 1'b1;
                    win_sel = 1'b1;
                end else if (m0_req) begin
                    win_vld = 1'b1;
                    win_sel = 1'b0;
                end
            end
            default: begin
                win_vld = 1'b0;
                win_sel = 1'b0;
            end
        endcase
    end

    // Next-state: ownership, tenure count, last winner and read-return tracking.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        last_nxt  = last;
        rpend_nxt = 1'b0;
        rsel_nxt  = rsel;
        win_write = win_sel ? m1_write : m0_write;
        win_state = win_sel ? OWN1 : OWN0;
        if (win_vld) begin
            state_nxt = win_state;
            last_nxt  = win_sel;
            if (state == win_state) begin
                cnt_nxt = cnt_full ? cnt : cnt + CNT_W'(1);
            end else begin
                cnt_nxt = CNT_W'(1);
            end
            if (!win_write) begin
                rpend_nxt = 1'b1;
                rsel_nxt  = win_sel;
            end
        end else begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
        end
    end

    // Outputs: memory mux from the winner; grants and rvalid forced low during reset.
    always_comb begin
        m0_gnt     = !rst && win_vld && !win_sel;
        m1_gnt     = !rst && win_vld &&  win_sel;
        DM_enable  = !rst && win_vld;
        DM_write   = !rst && win_vld && win_write;
        DM_address = win_sel ? m1_addr  : m0_addr;
        DM_in      = win_sel ? m1_wdata : m0_wdata;
        m0_rvalid  = !rst && rpend && !rsel;
        m1_rvalid  = !rst && rpend &&  rsel;
        m0_rdata   = DM_out;
        m1_rdata   = DM_out;
    end

    // State registers; last resets to 1 so master 0 wins the first contested IDLE.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            last  <= 1'b1;
            rpend <= 1'b0;
            rsel  <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            last  <= last_nxt;
            rpend <= rpend_nxt;
            rsel  <= rsel_nxt;
        end
    end

endmodule

// File: tb/tb_dm_arbiter.sv
// Directed bench for dm_arbiter: reset, single read, contention tenure, saturation, handover, write-then-read, reset during read.
// Inputs change on the falling edge; outputs are sampled 1 ns later, away from the rising edge.
// Memory read data is driven by the bench on the cycle after each expected read acceptance.
module tb_dm_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        m0_req, m0_write, m1_req, m1_write;
    logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
    logic        m0_gnt, m0_rvalid, m1_gnt, m1_rvalid;
    logic [31:0] m0_rdata, m1_rdata;
    logic        DM_enable, DM_write;
    logic [31:0] DM_address, DM_in, DM_out;

    int n_chk  = 0;
    int n_fail = 0;

    dm_arbiter #(.ADDR_W(32), .DATA_W(32), .BURST_MAX(4)) dut (
        .clk(clk), .rst(rst),
        .m0_req(m0_req), .m0_write(m0_write), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_write(m1_write), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
        .DM_enable(DM_enable), .DM_write(DM_write), .DM_address(DM_address),
        .DM_in(DM_in), .DM_out(DM_out)
    );

    always #5 clk = ~clk;

    // Advance to the next falling edge, apply inputs, settle 1 ns.
    task automatic drive(input logic r, input logic q0, input logic w0, input logic [31:0] a0,
                         input logic [31:0] d0, input logic q1, input logic w1,
                         input logic [31:0] a1, input logic [31:0] d1, input logic [31:0] dmo);
        @(negedge clk);
        rst = r; m0_req = q0; m0_write = w0; m0_addr = a0; m0_wdata = d0;
        m1_req = q1; m1_write = w1; m1_addr = a1; m1_wdata = d1; DM_out = dmo;
        #1;
    endtask

    task automatic test_reset();
        drive(1, 1, 1, 32'h4, 32'h0, 1, 1, 32'h8, 32'h0, 32'h0);
        drive(1, 1, 1, 32'h4, 32'h0, 1, 1, 32'h8, 32'h0, 32'h0);
        n_chk++; if ({m0_gnt, m1_gnt} !== 2'b00) begin n_fail++; $display("FAIL reset_gnt got=%b exp=00", {m0_gnt, m1_gnt}); end
        n_chk++; if ({m0_rvalid, m1_rvalid} !== 2'b00) begin n_fail++; $display("FAIL reset_rvalid got=%b exp=00", {m0_rvalid, m1_rvalid}); end
        n_chk++; if ({DM_enable, DM_write} !== 2'b00) begin n_fail++; $display("FAIL reset_dm got=%b exp=00", {DM_enable, DM_write}); end
    endtask

    task automatic test_single_read();
        drive(0, 1, 0, 32'h10, 32'h0, 0, 0, 32'h0, 32'h0, 32'h0);
        n_chk++; if ({m0_gnt, m1_gnt} !== 2'b10) begin n_fail++; $display("FAIL rd_gnt got=%b exp=10", {m0_gnt, m1_gnt}); end
        n_chk++; if ({DM_enable, DM_write} !== 2'b10) begin n_fail++; $display("FAIL rd_dm got=%b exp=10", {DM_enable, DM_write}); end
        n_chk++; if (DM_address !== 32'h10) begin n_fail++; $display("FAIL rd_addr got=%h exp=00000010", DM_address); end
        drive(0, 0, 0, 32'h0, 32'h0, 0, 0, 32'h0, 32'h0, 32'hDEADBEEF);
        n_chk++; if ({m0_rvalid, m1_rvalid} !== 2'b10) begin n_fail++; $display("FAIL rd_rvalid got=%b exp=10", {m0_rvalid, m1_rvalid}); end
        n_chk++; if (m0_rdata !== 32'hDEADBEEF) begin n_fail++; $display("FAIL rd_rdata got=%h exp=deadbeef", m0_rdata); end
        n_chk++; if (DM_enable !== 1'b0) begin n_fail++; $display("FAIL rd_idle_en got=%b exp=0", DM_enable); end
        drive(0, 0, 0, 32'h0, 32'h0, 0, 0, 32'h0, 32'h0, 32'h0);
        n_chk++; if ({m0_rvalid, m1_rvalid} !== 2'b00) begin n_fail++; $display("FAIL rd_rvalid_drop got=%b exp=00", {m0_rvalid, m1_rvalid}); end
    endtask

    // Both masters read continuously after reset: M0 first, 4-beat tenures, no gaps.
    task automatic test_contention();
        logic exp0, prev0;
        prev0 = 1'b0;
        drive(1, 0, 0, 32'h0, 32'h0, 0, 0, 32'h0, 32'h0, 32'h0);
        for (int i = 0; i < 16; i++) begin
            drive(0, 1, 0, 32'h100, 32'h0, 1, 0, 32'h200, 32'h0, 32'h0);
            exp0 = ((i / 4) % 2) == 0;
            n_chk++; if ({m0_gnt, m1_gnt} !== {exp0, !exp0}) begin n_fail++; $display("FAIL cont_gnt[%0d] got=%b exp=%b", i, {m0_gnt, m1_gnt}, {exp0, !exp0}); end
            n_chk++; if (DM_enable !== 1'b1) begin n_fail++; $display("FAIL cont_en[%0d] got=%b exp=1", i, DM_enable); end
            if (i == 0) begin
                n_chk++; if ({m0_rvalid, m1_rvalid} !== 2'b00) begin n_fail++; $display("FAIL cont_rv0 got=%b exp=00", {m0_rvalid, m1_rvalid}); end
            end else begin
                n_chk++; if ({m0_rvalid, m1_rvalid} !== {prev0, !prev0}) begin n_fail++; $display("FAIL cont_rv[%0d] got=%b exp=%b", i, {m0_rvalid, m1_rvalid}, {prev0, !prev0}); end
            end
            prev0 = exp0;
        end
        drive(0, 0, 0, 32'h0, 32'h0, 0, 0, 32'h0, 32'h0, 32'h0);
        n_chk++; if ({m0_rvalid, m1_rvalid} !== 2'b01) begin n_fail++; $display("FAIL cont_rv_last got=%b exp=01", {m0_rvalid, m1_rvalid}); end
    endtask

    // M1 alone saturates its count; M0 then wins at once and holds 4 beats before M1 returns.
    task automatic test_saturate();
        logic exp1;
        for (int i = 0; i < 10; i++) begin
            drive(0, 0, 1, 32'h0, 32'h0, 1, 1, 32'h300, 32'h55, 32'h0);
            n_chk++; if ({m0_gnt, m1_gnt, DM_write} !== 3'b011) begin n_fail++; $display("FAIL sat_m1[%0d] got=%b exp=011", i, {m0_gnt, m1_gnt, DM_write}); end
        end
        for (int i = 0; i < 6; i++) begin
            drive(0, 1, 1, 32'h400, 32'h66, 1, 1, 32'h300, 32'h55, 32'h0);
            exp1 = (i >= 4);
            n_chk++; if ({m0_gnt, m1_gnt} !== {!exp1, exp1}) begin n_fail++; $display("FAIL sat_both[%0d] got=%b exp=%b", i, {m0_gnt, m1_gnt}, {!exp1, exp1}); end
        end
        n_chk++; if (DM_address !== 32'h300 || DM_in !== 32'h55) begin n_fail++; $display("FAIL sat_mux got=%h/%h exp=00000300/00000055", DM_address, DM_in); end
        drive(0, 0, 0, 32'h0, 32'h0, 0, 0, 32'h0, 32'h0, 32'h0);
    endtask

    // Owner drops req while the other requests: handover in the same cycle.
    task automatic test_handover();
        drive(0, 1, 1, 32'h500, 32'h1, 0, 0, 32'h0, 32'h0, 32'h0);
        drive(0, 1, 1, 32'h500, 32'h1, 0, 0, 32'h0, 32'h0, 32'h0);
        drive(0, 0, 1, 32'h500, 32'h1, 1, 1, 32'h600, 32'h2, 32'h0);
        n_chk++; if ({m0_gnt, m1_gnt, DM_enable} !== 3'b011) begin n_fail++; $display("FAIL handover got=%b exp=011", {m0_gnt, m1_gnt, DM_enable}); end
        n_chk++; if (DM_address !== 32'h600) begin n_fail++; $display("FAIL handover_addr got=%h exp=00000600", DM_address); end
        drive(0, 0, 0, 32'h0, 32'h0, 0, 0, 32'h0, 32'h0, 32'h0);
        n_chk++; if ({m0_gnt, m1_gnt, DM_enable, DM_write} !== 4'b0000) begin n_fail++; $display("FAIL no_req got=%b exp=0000", {m0_gnt, m1_gnt, DM_enable, DM_write}); end
    endtask

    // M0 writes 0x1234 to 0x40, M1 reads 0x40 next cycle; only M1 sees rvalid.
    task automatic test_write_read();
        drive(0, 1, 1, 32'h40, 32'h1234, 0, 0, 32'h0, 32'h0, 32'h0);
        n_chk++; if ({m0_gnt, DM_enable, DM_write} !== 3'b111) begin n_fail++; $display("FAIL wr_ctl got=%b exp=111", {m0_gnt, DM_enable, DM_write}); end
        n_chk++; if (DM_address !== 32'h40 || DM_in !== 32'h1234) begin n_fail++; $display("FAIL wr_mux got=%h/%h exp=00000040/00001234", DM_address, DM_in); end
        drive(0, 0, 0, 32'h0, 32'h0, 1, 0, 32'h40, 32'h0, 32'h0);
        n_chk++; if ({m0_rvalid, m1_gnt, DM_write} !== 3'b010) begin n_fail++; $display("FAIL wr_rd_issue got=%b exp=010", {m0_rvalid, m1_gnt, DM_write}); end
        drive(0, 0, 0, 32'h0, 32'h0, 0, 0, 32'h0, 32'h0, 32'h1234);
        n_chk++; if ({m0_rvalid, m1_rvalid} !== 2'b01) begin n_fail++; $display("FAIL wr_rd_rvalid got=%b exp=01", {m0_rvalid, m1_rvalid}); end
        n_chk++; if (m1_rdata !== 32'h1234) begin n_fail++; $display("FAIL wr_rd_data got=%h exp=00001234", m1_rdata); end
    endtask

    // Reset right after an accepted read suppresses rvalid; arbiter restarts from IDLE with M0 priority.
    task automatic test_reset_inflight();
        drive(0, 0, 0, 32'h0, 32'h0, 1, 0, 32'h700, 32'h0, 32'h0);
        drive(0, 1, 0, 32'h80, 32'h0, 0, 0, 32'h0, 32'h0, 32'h0);
        n_chk++; if (m0_gnt !== 1'b1) begin n_fail++; $display("FAIL rstif_gnt got=%b exp=1", m0_gnt); end
        drive(1, 1, 1, 32'h80, 32'h0, 1, 1, 32'h0, 32'h0, 32'hBAD0BAD0);
        n_chk++; if ({m0_rvalid, m1_rvalid} !== 2'b00) begin n_fail++; $display("FAIL rstif_rvalid got=%b exp=00", {m0_rvalid, m1_rvalid}); end
        n_chk++; if ({m0_gnt, m1_gnt, DM_enable, DM_write} !== 4'b0000) begin n_fail++; $display("FAIL rstif_out got=%b exp=0000", {m0_gnt, m1_gnt, DM_enable, DM_write}); end
        drive(0, 0, 0, 32'h0, 32'h0, 0, 0, 32'h0, 32'h0, 32'h0);
        n_chk++; if ({m0_rvalid, m1_rvalid, DM_enable} !== 3'b000) begin n_fail++; $display("FAIL rstif_after got=%b exp=000", {m0_rvalid, m1_rvalid, DM_enable}); end
        drive(0, 1, 0, 32'h90, 32'h0, 1, 0, 32'h94, 32'h0, 32'h0);
        n_chk++; if ({m0_gnt, m1_gnt} !== 2'b10) begin n_fail++; $display("FAIL rstif_prio got=%b exp=10", {m0_gnt, m1_gnt}); end
        drive(0, 0, 0, 32'h0, 32'h0, 0, 0, 32'h0, 32'h0, 32'h0);
        n_chk++; if ({m0_rvalid, m1_rvalid} !== 2'b10) begin n_fail++; $display("FAIL rstif_rv_new got=%b exp=10", {m0_rvalid, m1_rvalid}); end
    endtask

    initial begin
        rst = 1'b1; m0_req = 1'b0; m0_write = 1'b0; m0_addr = '0; m0_wdata = '0;
        m1_req = 1'b0; m1_write = 1'b0; m1_addr = '0; m1_wdata = '0; DM_out = '0;
        test_reset();
        test_single_read();
        test_contention();
        test_saturate();
        test_handover();
        test_write_read();
        test_reset_inflight();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/dm_arbiter.md
# dm_arbiter

Two-requester arbiter that shares the single synchronous data memory (DM) port between the CPU data port (master 0) and a secondary master such as a DMA or loader (master 1). It sits between `top` and `DM`. Arbitration is round-robin with a bounded tenure, so neither master can starve the other. It issues one memory access per cycle and routes the 1-cycle-latency read data back to the master that issued the read.

## Interface
Parameters:
- `ADDR_W`, 32, address width.
- `DATA_W`, 32, data width.
- `BURST_MAX`, 4, maximum consecutive beats one master may hold while the other is requesting. Must be ≥1.

Ports (one clock; reset is synchronous and active-high):
- `clk`  in  1  system clock, all state on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `m0_req`, `m1_req`  in  1  access request, held until granted.
- `m0_write`, `m1_write`  in  1  1 = write, 0 = read.
- `m0_addr`, `m1_addr`  in  ADDR_W  byte address, passed through unchanged.
- `m0_wdata`, `m1_wdata`  in  DATA_W  write data.
- `m0_gnt`, `m1_gnt`  out  1  combinational grant; a beat is accepted when req && gnt.
- `m0_rvalid`, `m1_rvalid`  out  1  read data valid, registered.
- `m0_rdata`, `m1_rdata`  out  DATA_W  equals `DM_out`; meaningful only with rvalid.
- `DM_enable`  out  1  memory enable, asserted for an accepted beat.
- `DM_write`  out  1  write strobe of the winning master, gated by `DM_enable`.
- `DM_address`  out  ADDR_W  address of the winner.
- `DM_in`  out  DATA_W  write data of the winner.
- `DM_out`  in  DATA_W  memory read data, valid the cycle after a read enable.

## Operation
- State machine `state` ∈ {IDLE, OWN0, OWN1}, plus registers `cnt` (0..BURST_MAX), `last` (last winner), `rsel` and `rpend` (read return tracking).
- Winner selection, combinational from state and requests:
  - IDLE, both requesting: the master ≠ `last` wins.
  - IDLE, one requesting: that master wins.
  - OWNx: x wins if `mx_req` && !(`cnt`==BURST_MAX && `my_req`).
  - OWNx, otherwise: y wins if `my_req`.
  - Otherwise: no winner.
- At most one gnt per cycle. gnt is never asserted to a non-requesting master.
- Memory mux: `DM_enable` = any winner. `DM_write`, `DM_address` and `DM_in` come from the winner. With no winner, `DM_enable`=0 and `DM_write`=0.
- Next state:
  - Winner w: `state`←OWNw, `last`←w.
  - `cnt`←min(`cnt`+1, BURST_MAX) if w equals the current owner, else 1.
  - No winner: `state`←IDLE, `cnt`←0; `last` holds.
- Read return: an accepted read sets `rpend`←1 and `rsel`←w. Any other cycle sets `rpend`←0. `mx_rvalid` = `rpend` && (`rsel`==x).
- Writes have no response; they complete on acceptance.
- Back-to-back reads from alternating masters are legal. Each master gets its rvalid in the cycle after its own grant.

## Timing
- Reset: `state`=IDLE, `cnt`=0, `last`=1 (so master 0 wins the first contested IDLE), `rpend`=0.
- During `rst`, all gnt, rvalid, `DM_enable` and `DM_write` outputs are forced to 0.
- Grant latency is 0 cycles: gnt is asserted in the same cycle as req when the master wins.
- Read latency is 1 cycle: rvalid and valid `DM_out` arrive in the cycle after acceptance.
- Tenure under contention is exactly BURST_MAX beats, then ownership hands over with no idle cycle.
- An uncontested owner keeps the port indefinitely (`cnt` saturates). When the other master then requests while `cnt`==BURST_MAX, it wins on the next request cycle.
- An owner that drops req hands over in the same cycle if the other master is requesting. No bubble is inserted.
- Reset asserted while a read is in flight: the read's rvalid is suppressed. After reset, no stale rvalid appears.
- A write followed by a read to the same address in the next cycle returns the new data, because DM is write-first-cycle then read.

## Test plan
- Reset, then a single read: `m0_req`=1, `m0_addr`=0x10, `DM_out`=0xDEAD_BEEF in the next cycle -> `m0_gnt`=1 the same cycle; `m0_rvalid`=1 one cycle later with rdata 0xDEAD_BEEF; `m1_rvalid`=0.
- Both masters request from IDLE immediately after reset -> master 0 is granted first.
- Both masters request continuously with BURST_MAX=4 for 16 cycles -> grants run M0×4, M1×4, M0×4, M1×4 with no gaps; `DM_enable` is high for all 16 cycles.
- M1 alone for 10 beats, then M0 requests -> M0 is granted in the first cycle it requests (M1's `cnt` is saturated); M1 regains the port after M0 releases or after 4 M0 beats.
- M0 writes 0x1234 to 0x40, then M1 reads 0x40 the next cycle -> `m1_rvalid` is asserted with 0x1234 and `m0_rvalid` stays 0 throughout.
- M0 read accepted, `rst` asserted in the next cycle -> `m0_rvalid` is 0, all gnt outputs are 0, and after release `state`=IDLE with no spurious rvalid.
